// File: rtl/riscv_axi_mem_arbiter_pkg.sv
// Shared types and constants for the AXI-Lite / CPU memory arbiter.
package riscv_axi_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StRdResp,
        StBResp
    } arb_state_e;

    typedef enum logic {
        ReqAxi = 1'b0,
        ReqCpu = 1'b1
    } req_id_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/riscv_axi_wr_capture.sv
// Independent AW and W channel capture; each channel is held until the write
// is granted to memory.
module riscv_axi_wr_capture #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    riscv_cpu_clk,
    input  logic                    riscv_cpu_reset,
    input  logic                    accept_en,
    input  logic                    clear,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic                    aw_held,
    output logic                    w_held,
    output logic [ADDR_WIDTH-3:0]   held_word_addr,
    output logic [DATA_WIDTH-1:0]   held_data,
    output logic [DATA_WIDTH/8-1:0] held_strb
);

    logic                    aw_held_q, w_held_q;
    logic [ADDR_WIDTH-3:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH/8-1:0] strb_q;
    logic                    unused_awaddr_lsbs;

    assign unused_awaddr_lsbs = ^awaddr[1:0];

    assign awready        = accept_en && !aw_held_q;
    assign wready         = accept_en && !w_held_q;
    assign aw_held        = aw_held_q;
    assign w_held         = w_held_q;
    assign held_word_addr = addr_q;
    assign held_data      = data_q;
    assign held_strb      = strb_q;

    // clear only fires with both channels held, so it never races a new capture
    always_ff @(posedge riscv_cpu_clk or posedge riscv_cpu_reset) begin
        if (riscv_cpu_reset) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            if (clear) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end
            if (awvalid && awready) begin
                aw_held_q <= 1'b1;
                addr_q    <= awaddr[ADDR_WIDTH-1:2];
            end
            if (wvalid && wready) begin
                w_held_q <= 1'b1;
                data_q   <= wdata;
                strb_q   <= wstrb;
            end
        end
    end

endmodule

// File: rtl/riscv_axi_mem_arbiter.sv
// Arbitrates a single-port word memory between an AXI4-Lite slave and the CPU
// data port, alternating under contention.
module riscv_axi_mem_arbiter
    import riscv_axi_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    riscv_cpu_clk,
    input  logic                    riscv_cpu_reset,
    input  logic [ADDR_WIDTH-1:0]   riscv_cpu_axi_if_awaddr,
    input  logic                    riscv_cpu_axi_if_awvalid,
    output logic                    riscv_cpu_axi_if_awready,
    input  logic [DATA_WIDTH-1:0]   riscv_cpu_axi_if_wdata,
    input  logic [DATA_WIDTH/8-1:0] riscv_cpu_axi_if_wstrb,
    input  logic                    riscv_cpu_axi_if_wvalid,
    output logic                    riscv_cpu_axi_if_wready,
    output logic [1:0]              riscv_cpu_axi_if_bresp,
    output logic                    riscv_cpu_axi_if_bvalid,
    input  logic                    riscv_cpu_axi_if_bready,
    input  logic [ADDR_WIDTH-1:0]   riscv_cpu_axi_if_araddr,
    input  logic                    riscv_cpu_axi_if_arvalid,
    output logic                    riscv_cpu_axi_if_arready,
    output logic [DATA_WIDTH-1:0]   riscv_cpu_axi_if_rdata,
    output logic [1:0]              riscv_cpu_axi_if_rresp,
    output logic                    riscv_cpu_axi_if_rvalid,
    input  logic                    riscv_cpu_axi_if_rready,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
    output logic                    cpu_gnt,
    output logic                    cpu_rvalid,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-3:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    arb_state_e              state_q, state_d;
    req_id_e                 last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q;
    logic                    cpu_rvalid_q;
    logic                    accept_en, wr_clear, aw_held, w_held, wr_pend;
    logic                    ar_open, ar_fire, axi_pend;
    logic [ADDR_WIDTH-3:0]   held_word_addr;
    logic [DATA_WIDTH-1:0]   held_data;
    logic [DATA_WIDTH/8-1:0] held_strb;
    logic                    unused_addr_lsbs;

    assign unused_addr_lsbs = ^{riscv_cpu_axi_if_araddr[1:0], cpu_addr[1:0]};

    riscv_axi_wr_capture #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_capture (
        .riscv_cpu_clk   (riscv_cpu_clk),
        .riscv_cpu_reset (riscv_cpu_reset),
        .accept_en       (accept_en),
        .clear           (wr_clear),
        .awaddr          (riscv_cpu_axi_if_awaddr),
        .awvalid         (riscv_cpu_axi_if_awvalid),
        .awready         (riscv_cpu_axi_if_awready),
        .wdata           (riscv_cpu_axi_if_wdata),
        .wstrb           (riscv_cpu_axi_if_wstrb),
        .wvalid          (riscv_cpu_axi_if_wvalid),
        .wready          (riscv_cpu_axi_if_wready),
        .aw_held         (aw_held),
        .w_held          (w_held),
        .held_word_addr  (held_word_addr),
        .held_data       (held_data),
        .held_strb       (held_strb)
    );

    assign accept_en = (state_q == StIdle) && !riscv_cpu_reset;
    assign wr_pend   = aw_held && w_held;
    assign ar_open   = accept_en && !aw_held && !w_held;
    assign axi_pend  = wr_pend || (ar_open && riscv_cpu_axi_if_arvalid);
    // arready is withheld when a contending CPU request owns this cycle
    assign riscv_cpu_axi_if_arready = ar_open && !(cpu_req && last_grant_q == ReqAxi);
    assign ar_fire   = riscv_cpu_axi_if_arvalid && riscv_cpu_axi_if_arready;

    assign riscv_cpu_axi_if_rvalid = (state_q == StRdResp) && !riscv_cpu_reset;
    assign riscv_cpu_axi_if_bvalid = (state_q == StBResp) && !riscv_cpu_reset;
    assign riscv_cpu_axi_if_rresp  = AXI_RESP_OKAY;
    assign riscv_cpu_axi_if_bresp  = AXI_RESP_OKAY;
    assign riscv_cpu_axi_if_rdata  = rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : cpu_rdata_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rdata_d      = rdata_q;
        cpu_gnt      = 1'b0;
        wr_clear     = 1'b0;
        mem_en       = 1'b0;
        mem_we       = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (!riscv_cpu_reset) begin
            unique case (state_q)
                StIdle: begin
                    if (cpu_req && (!axi_pend || last_grant_q == ReqAxi)) begin
                        cpu_gnt = 1'b1;
                    end else if (wr_pend) begin
                        mem_en       = 1'b1;
                        mem_we       = held_strb;
                        mem_addr     = held_word_addr;
                        mem_wdata    = held_data;
                        wr_clear     = 1'b1;
                        last_grant_d = ReqAxi;
                        state_d      = StBResp;
                    end else if (ar_fire) begin
                        mem_en       = 1'b1;
                        mem_addr     = riscv_cpu_axi_if_araddr[ADDR_WIDTH-1:2];
                        last_grant_d = ReqAxi;
                        state_d      = StRdWait;
                    end
                end
                StRdWait: begin
                    rdata_d = mem_rdata;
                    state_d = StRdResp;
                end
                StRdResp: begin
                    cpu_gnt = cpu_req;
                    if (riscv_cpu_axi_if_rready) state_d = StIdle;
                end
                StBResp: begin
                    cpu_gnt = cpu_req;
                    if (riscv_cpu_axi_if_bready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
            if (cpu_gnt) begin
                mem_en       = 1'b1;
                mem_we       = cpu_we ? cpu_wstrb : '0;
                mem_addr     = cpu_addr[ADDR_WIDTH-1:2];
                mem_wdata    = cpu_wdata;
                last_grant_d = ReqCpu;
            end
        end
    end

    always_ff @(posedge riscv_cpu_clk or posedge riscv_cpu_reset) begin
        if (riscv_cpu_reset) begin
            state_q      <= StIdle;
            last_grant_q <= ReqCpu;
            rdata_q      <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rdata_q      <= rdata_d;
            cpu_rvalid_q <= cpu_gnt && !cpu_we;
            if (cpu_rvalid_q) cpu_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_riscv_axi_mem_arbiter.sv
// Directed self-checking bench for riscv_axi_mem_arbiter with a behavioural
// single-port synchronous-read memory.
module tb_riscv_axi_mem_arbiter;

    logic        clk, rst;
    logic [13:0] awaddr, araddr, cpu_addr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
    logic [3:0]  wstrb, cpu_wstrb, mem_we;
    logic [1:0]  bresp, rresp;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, mem_en;
    logic [11:0] mem_addr;

    logic [31:0] mem_model [0:4095];
    int          wr_count;
    int          errors = 0;
    int          checks = 0;

    riscv_axi_mem_arbiter #(
        .ADDR_WIDTH (14),
        .DATA_WIDTH (32)
    ) dut (
        .riscv_cpu_clk            (clk),
        .riscv_cpu_reset          (rst),
        .riscv_cpu_axi_if_awaddr  (awaddr),
        .riscv_cpu_axi_if_awvalid (awvalid),
        .riscv_cpu_axi_if_awready (awready),
        .riscv_cpu_axi_if_wdata   (wdata),
        .riscv_cpu_axi_if_wstrb   (wstrb),
        .riscv_cpu_axi_if_wvalid  (wvalid),
        .riscv_cpu_axi_if_wready  (wready),
        .riscv_cpu_axi_if_bresp   (bresp),
        .riscv_cpu_axi_if_bvalid  (bvalid),
        .riscv_cpu_axi_if_bready  (bready),
        .riscv_cpu_axi_if_araddr  (araddr),
        .riscv_cpu_axi_if_arvalid (arvalid),
        .riscv_cpu_axi_if_arready (arready),
        .riscv_cpu_axi_if_rdata   (rdata),
        .riscv_cpu_axi_if_rresp   (rresp),
        .riscv_cpu_axi_if_rvalid  (rvalid),
        .riscv_cpu_axi_if_rready  (rready),
        .cpu_req                  (cpu_req),
        .cpu_we                   (cpu_we),
        .cpu_addr                 (cpu_addr),
        .cpu_wdata                (cpu_wdata),
        .cpu_wstrb                (cpu_wstrb),
        .cpu_gnt                  (cpu_gnt),
        .cpu_rvalid               (cpu_rvalid),
        .cpu_rdata                (cpu_rdata),
        .mem_en                   (mem_en),
        .mem_we                   (mem_we),
        .mem_addr                 (mem_addr),
        .mem_wdata                (mem_wdata),
        .mem_rdata                (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= mem_model[mem_addr];
            if (mem_we != 4'h0) wr_count <= wr_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b1; arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rst_awready: got %b expected 0", awready); end
        checks++; if (wready !== 1'b0) begin errors++; $display("FAIL rst_wready: got %b expected 0", wready); end
        checks++; if (arready !== 1'b0) begin errors++; $display("FAIL rst_arready: got %b expected 0", arready); end
        checks++; if (rvalid !== 1'b0 || bvalid !== 1'b0) begin errors++; $display("FAIL rst_valids: got r=%b b=%b expected 0", rvalid, bvalid); end
        checks++; if (cpu_gnt !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rst_cpu: got gnt=%b rvalid=%b expected 0", cpu_gnt, cpu_rvalid); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 4'h0) begin errors++; $display("FAIL rst_mem: got en=%b we=%h expected 0", mem_en, mem_we); end
        cpu_req = 1'b0; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (awready !== 1'b1 || wready !== 1'b1) begin errors++; $display("FAIL post_rst_aw_w_ready: got %b%b expected 11", awready, wready); end
        checks++; if (arready !== 1'b1) begin errors++; $display("FAIL post_rst_arready: got %b expected 1", arready); end
        checks++; if (rdata !== 32'h0 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL post_rst_data: got %h %h expected 0", rdata, cpu_rdata); end
        tick();
    endtask

    task automatic test_axi_write();
        int w0;
        w0 = wr_count;
        awaddr = 14'h0010; awvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        checks++; if (awready !== 1'b1) begin errors++; $display("FAIL wr_awready: got %b expected 1", awready); end
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (awready !== 1'b0 || arready !== 1'b0 || wready !== 1'b1) begin errors++; $display("FAIL wr_aw_held: got aw=%b ar=%b w=%b expected 0 0 1", awready, arready, wready); end
            checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL wr_early_mem_en: got %b expected 0", mem_en); end
            tick();
        end
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        checks++; if (wready !== 1'b1) begin errors++; $display("FAIL wr_wready: got %b expected 1", wready); end
        tick();
        wvalid = 1'b0;
        @(negedge clk);
        checks++; if (mem_en !== 1'b1 || mem_we !== 4'hF) begin errors++; $display("FAIL wr_mem_en_we: got %b %h expected 1 f", mem_en, mem_we); end
        checks++; if (mem_addr !== 12'd4 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem_addr_data: got %h %h expected 004 deadbeef", mem_addr, mem_wdata); end
        tick();
        @(negedge clk);
        checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL wr_bresp: got %b %b expected 1 00", bvalid, bresp); end
        tick();
        @(negedge clk);
        checks++; if (bvalid !== 1'b0 || awready !== 1'b1) begin errors++; $display("FAIL wr_b_done: got b=%b aw=%b expected 0 1", bvalid, awready); end
        checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL wr_single: got %0d writes expected 1", wr_count - w0); end
        checks++; if (mem_model[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem_word4: got %h expected deadbeef", mem_model[4]); end
        bready = 1'b0;
        tick();
    endtask

    task automatic test_axi_read();
        araddr = 14'h0010; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        checks++; if (arready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'h0) begin errors++; $display("FAIL rd_issue: got ar=%b en=%b we=%h expected 1 1 0", arready, mem_en, mem_we); end
        checks++; if (mem_addr !== 12'd4) begin errors++; $display("FAIL rd_addr: got %h expected 004", mem_addr); end
        tick();
        arvalid = 1'b0;
        @(negedge clk);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rd_wait_rvalid: got %b expected 0", rvalid); end
        tick();
        @(negedge clk);
        checks++; if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rresp !== 2'b00) begin errors++; $display("FAIL rd_resp: got %b %h %b expected 1 deadbeef 00", rvalid, rdata, rresp); end
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            checks++; if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: got %b %h expected 1 deadbeef", rvalid, rdata); end
        end
        tick();
        rready = 1'b1;
        @(negedge clk);
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rd_pre_handshake: got %b expected 1", rvalid); end
        tick();
        rready = 1'b0;
        @(negedge clk);
        checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL rd_done: got r=%b ar=%b expected 0 1", rvalid, arready); end
        tick();
    endtask

    task automatic test_alternate();
        int seq [0:7];
        int n_axi, n_cpu, n;
        logic prev_cpu_rd;
        n_axi = 0; n_cpu = 0; n = 0; prev_cpu_rd = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        araddr = 14'h0010; arvalid = 1'b1; rready = 1'b1;
        cpu_addr = 14'h0010; cpu_we = 1'b0; cpu_req = 1'b1;
        for (int cyc = 0; cyc < 40 && (n_axi < 4 || n_cpu < 4); cyc++) begin
            @(negedge clk);
            if (prev_cpu_rd) begin
                checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL alt_cpu_rdata: got %b %h expected 1 deadbeef", cpu_rvalid, cpu_rdata); end
            end
            if (rvalid) begin
                checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL alt_axi_rdata: got %h expected deadbeef", rdata); end
            end
            prev_cpu_rd = cpu_gnt;
            if (arvalid && arready && n < 8) begin seq[n] = 0; n++; n_axi++; end
            if (cpu_gnt && n < 8) begin seq[n] = 1; n++; n_cpu++; end
            tick();
            if (n_axi >= 4) arvalid = 1'b0;
            if (n_cpu >= 4) cpu_req = 1'b0;
        end
        arvalid = 1'b0; cpu_req = 1'b0; rready = 1'b0;
        checks++; if (n !== 8) begin errors++; $display("FAIL alt_grant_count: got %0d expected 8", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (seq[i] !== (i % 2)) begin errors++; $display("FAIL alt_order[%0d]: got %0d expected %0d (0=AXI 1=CPU)", i, seq[i], i % 2); end
        end
        tick();
        tick();
    endtask

    task automatic test_cpu_during_bresp();
        awaddr = 14'h0030; awvalid = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        checks++; if (mem_en !== 1'b1 || mem_addr !== 12'd12) begin errors++; $display("FAIL br_axi_write: got %b %h expected 1 00c", mem_en, mem_addr); end
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_wstrb = 4'h3; cpu_wdata = 32'h12345678;
        cpu_addr = 14'h0020;
        @(negedge clk);
        checks++; if (bvalid !== 1'b1 || cpu_gnt !== 1'b1) begin errors++; $display("FAIL br_cpu_gnt: got b=%b gnt=%b expected 1 1", bvalid, cpu_gnt); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 4'h3 || mem_addr !== 12'd8) begin errors++; $display("FAIL br_cpu_mem: got %b %h %h expected 1 3 008", mem_en, mem_we, mem_addr); end
        checks++; if (mem_wdata !== 32'h12345678) begin errors++; $display("FAIL br_cpu_wdata: got %h expected 12345678", mem_wdata); end
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        checks++; if (bvalid !== 1'b1 || cpu_gnt !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL br_after: got b=%b gnt=%b rv=%b expected 1 0 0", bvalid, cpu_gnt, cpu_rvalid); end
        checks++; if (mem_model[8][15:0] !== 16'h5678) begin errors++; $display("FAIL br_mem_word8: got %h expected 5678", mem_model[8][15:0]); end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        @(negedge clk);
        checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL br_done: got %b expected 0", bvalid); end
        tick();
    endtask

    task automatic test_reset_in_rdresp();
        araddr = 14'h0010; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rr_in_resp: got %b expected 1", rvalid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rvalid !== 1'b0 || arready !== 1'b0) begin errors++; $display("FAIL rr_async_drop: got r=%b ar=%b expected 0 0", rvalid, arready); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rr_rdata_clr: got %h expected 0", rdata); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (arready !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL rr_release: got ar=%b r=%b expected 1 0", arready, rvalid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rr_stale_rvalid: got %b expected 0", rvalid); end
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        #1;
        test_reset();
        test_axi_write();
        test_axi_read();
        test_alternate();
        test_cpu_during_bresp();
        test_reset_in_rdresp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
